// File: rtl/rgb_pwm_pkg.sv
// Shared constants, FSM encoding and the gamma curve for the RGB PWM fader.
package rgb_pwm_pkg;

  localparam int R = 0;
  localparam int G = 1;
  localparam int B = 2;

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } state_e;

  // Square-law brightness curve: (x*(x+1)) >> n at double width, so full scale maps to full scale.
  function automatic logic [31:0] gamma_map(input logic [15:0] x, input int unsigned n);
    logic [31:0] prod;
    prod = 32'(x) * (32'(x) + 32'd1);
    return prod >> n;
  endfunction

endpackage

// File: rtl/pwm_chan.sv
// One colour channel: current/target duty, step-toward logic, period shadow and registered PWM bit.
// RGB_PWM_GAMMA_EN selects a gamma-corrected shadow instead of the raw duty.
module pwm_chan
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic                load,
  input  logic                set_cur,
  input  logic                set_tgt,
  input  logic                step,
  input  logic [PWM_BITS-1:0] cmd_duty,
  output logic                at_tgt,
  output logic                pwm
);

  logic [PWM_BITS-1:0] cur_q, cur_d;
  logic [PWM_BITS-1:0] tgt_q, tgt_d;
  logic [PWM_BITS-1:0] shadow_q, shadow_d;
  logic                pwm_q, pwm_d;

`ifdef RGB_PWM_GAMMA_EN
  // The curve is registered a cycle ahead so the shadow still loads on the same count.
  logic [PWM_BITS-1:0] gamma_q, gamma_d;

  always_comb begin
    gamma_d = PWM_BITS'(gamma_map(16'(cur_q), PWM_BITS));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gamma_q <= '0;
    end else begin
      gamma_q <= gamma_d;
    end
  end
`endif

  always_comb begin
    cur_d = cur_q;
    if (set_cur) begin
      cur_d = cmd_duty;
    end else if (step && (cur_q < tgt_q)) begin
      cur_d = cur_q + 1'b1;
    end else if (step && (cur_q > tgt_q)) begin
      cur_d = cur_q - 1'b1;
    end
  end

  always_comb begin
    tgt_d = set_tgt ? cmd_duty : tgt_q;
  end

  always_comb begin
    shadow_d = shadow_q;
    if (load) begin
`ifdef RGB_PWM_GAMMA_EN
      shadow_d = gamma_q;
`else
      shadow_d = cur_q;
`endif
    end
  end

  always_comb begin
    pwm_d = (cnt < shadow_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q    <= '0;
      tgt_q    <= '0;
      shadow_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      cur_q    <= cur_d;
      tgt_q    <= tgt_d;
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
    end
  end

  assign at_tgt = (cur_q == tgt_q);
  assign pwm    = pwm_q;

endmodule

// File: rtl/rgb_pwm_fader.sv
// Colour command front end for the iCE40 RGB driver: shared period counter, ramp divider and fade FSM.
// Define RGB_PWM_GAMMA_EN to gamma-correct each channel's duty before it reaches the PWM compare.
module rgb_pwm_fader
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int RAMP_DIV = 32000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [PWM_BITS-1:0] cmd_r,
  input  logic [PWM_BITS-1:0] cmd_g,
  input  logic [PWM_BITS-1:0] cmd_b,
  input  logic                cmd_fade,
  output logic [2:0]          pwm,
  output logic                busy
);

  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((1 << PWM_BITS) - 2);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(RAMP_DIV - 1);

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  state_e              state_q, state_d;

  logic                load;
  logic                set_cur;
  logic                set_tgt;
  logic                step;
  logic [2:0]          at_tgt;
  logic [PWM_BITS-1:0] cmd_duty [3];

  assign cmd_duty[R] = cmd_r;
  assign cmd_duty[G] = cmd_g;
  assign cmd_duty[B] = cmd_b;

  // Period is 2^N-1 so a duty of all-ones stays high for the whole period.
  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    load  = (cnt_q == CNT_LAST);
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    set_cur = 1'b0;
    set_tgt = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          set_tgt = 1'b1;
          if (cmd_fade) begin
            state_d = FADE;
            div_d   = '0;
          end else begin
            set_cur = 1'b1;
          end
        end
      end
      FADE: begin
        // Arrival is checked before stepping, so a fade ends one cycle after the last step.
        if (&at_tgt) begin
          state_d = IDLE;
        end else if (div_q == DIV_LAST) begin
          step  = 1'b1;
          div_d = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      div_q   <= '0;
      state_q <= IDLE;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      state_q <= state_d;
    end
  end

  assign cmd_ready = (state_q == IDLE) && !rst;
  assign busy      = (state_q == FADE);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      pwm_chan #(
        .PWM_BITS (PWM_BITS)
      ) u_chan (
        .clk      (clk),
        .rst      (rst),
        .cnt      (cnt_q),
        .load     (load),
        .set_cur  (set_cur),
        .set_tgt  (set_tgt),
        .step     (step),
        .cmd_duty (cmd_duty[gi]),
        .at_tgt   (at_tgt[gi]),
        .pwm      (pwm[gi])
      );
    end
  endgenerate

endmodule

// File: doc/rgb_pwm_fader.md
Name: rgb_pwm_fader

Overview:
- Upstream stage for the iCE40 RGB LED driver primitive.
- Accepts colour commands over a valid/ready handshake, ramps each channel's duty toward its target, and emits three glitch-free PWM bits.
- The three outputs wire directly to RGB0PWM/RGB1PWM/RGB2PWM; the driver current setting stays outside this block.

Parameters:
- PWM_BITS, 8, duty resolution N; PWM period is 2^N-1 clk cycles.
- RAMP_DIV, 32000, clk cycles per ±1 duty step while fading; minimum 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_r  input  PWM_BITS  red target duty.
- cmd_g  input  PWM_BITS  green target duty.
- cmd_b  input  PWM_BITS  blue target duty.
- cmd_fade  input  1  1 = ramp to target; 0 = jump to target.
- pwm  output  3  [0]=red, [1]=green, [2]=blue; active-high PWM.
- busy  output  1  fade in progress.

Behaviour:
- Reset (async assert; release synchronous to clk):
  - period counter cnt=0; cur, tgt and shadow duties = 0; pwm=0; state=IDLE; busy=0; cmd_ready=1 once rst is low.
- PWM generation:
  - cnt counts 0..2^N-2, then wraps to 0.
  - pwm[i] is registered: pwm[i] <= (cnt < shadow[i]).
  - Duty 0 gives constant low; duty 2^N-1 gives constant high.
- Shadow load:
  - Shadows load from cur (via gamma if enabled) only on the cycle cnt==2^N-2, taking effect from cnt=0.
  - Duty never changes mid-period, so there is no runt pulse.
- State machine:
  - IDLE → FADE on handshake when cmd_fade=1.
  - FADE → IDLE when cur==tgt on all channels.
- Handshake:
  - Transfer occurs when cmd_valid & cmd_ready on a rising edge.
  - cmd_ready = (state==IDLE).
  - Commands are fields-latched on the handshake cycle.
- Command in IDLE with cmd_fade=0: tgt and cur both set to the command; state stays IDLE.
- Command in IDLE with cmd_fade=1: tgt set; ramp divider cleared; state → FADE.
- FADE operation:
  - cmd_ready=0 and busy=1.
  - Each cycle, if cur==tgt on all channels, → IDLE; this check precedes stepping.
  - Otherwise the divider counts 0..RAMP_DIV-1. At terminal count, each channel with cur≠tgt steps by 1 toward tgt, independently.
  - Channels never overshoot.
- Fade completion timing:
  - A fade whose target equals cur returns to IDLE one cycle after acceptance.
  - A fade of distance D completes D*RAMP_DIV+1 cycles after acceptance.
- cmd_valid is ignored while in FADE; the upstream must hold it.
- rst asserted mid-fade: immediate return to reset values; pwm goes 0 without waiting for the period end.
- Width rules: duties are unsigned PWM_BITS. Stepping uses compare-then-±1, so there is no wrap at 0 or 2^N-1.

Optional Feature:
- Macro RGB_PWM_GAMMA_EN.
- Defined: shadow[i] = (cur[i]*(cur[i]+1)) >> N, computed at 2N bits.
  - Maps 0→0, 1→0, 2^N-1→2^N-1, and midpoint 128→64 for N=8.
  - The multiplier is registered one cycle earlier so the shadow load timing is unchanged.
- Undefined: shadow[i] = cur[i].

Decomposition:
- Package rgb_pwm_pkg holds:
  - channel index constants R=0, G=1, B=2;
  - state encoding IDLE/FADE;
  - a gamma function.
- One sub-module, pwm_chan, instantiated 3×: shadow register, compare, registered output, and the per-channel step-toward logic.
- The shared cnt, ramp divider and FSM live in the top.

Test Plan (PWM_BITS=8, RAMP_DIV=4, gamma off unless stated):
- Reset: assert rst mid-period with pwm high → pwm=000 the same cycle; after release cmd_ready=1, busy=0, pwm stays 000 for ≥2 periods.
- Immediate set: send r=255,g=0,b=128,fade=0 → from next cnt=0, pwm[0] constant 1, pwm[1] constant 0, pwm[2] high exactly 128 of every 255 cycles; no partial pulse in the period of the command.
- Fade: from 0, send r=10,fade=1 → busy=1 and cmd_ready=0 for 41 cycles; cur_r increments every 4 cycles; IDLE after reaching 10.
- Mixed directions: from r=5,g=0, fade to r=0,g=3 → r decrements and g increments on shared ticks; g holds at 3 while r finishes; total 21 cycles busy.
- Backpressure plus zero-length fade: hold cmd_valid during a fade → accepted on the first IDLE cycle. A fade to the current colour → busy for exactly 1 cycle.
- RGB_PWM_GAMMA_EN: immediate r=128 → high 64 cycles/period; r=1 → constant 0; r=255 → constant 1.
